// File: rtl/i2c_slave_regfile.sv
// I2C slave with a DEPTH-byte register file: write {addr,W},ptr,data... and read via Sr,{addr,R}.
// Optional 3-sample majority glitch filter on SCL/SDA when I2C_GLITCH_FILTER_EN is defined.
module i2c_slave_regfile #(
   parameter logic [6:0] SLAVE_ADDR = 7'b0010000,
   parameter int         DEPTH      = 8,
   parameter int         ADDR_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   output logic              busy,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic [7:0]        host_rdata,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_MEMADDR  = 3'd3,
      ST_WRDATA   = 3'd4,
      ST_RDDATA   = 3'd5,
      ST_RD_NACK  = 3'd6
   } state_t;

   logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
   logic scl_f_s, sda_f_s, scl_prev_q, sda_prev_q;
   logic scl_rise_s, scl_fall_s, start_s, stop_s;

   state_t            state_q;
   logic [3:0]        bitcnt_q;
   logic [7:0]        shreg_q;
   logic [7:0]        byte_d;
   logic [ADDR_W-1:0] ptr_q, ptr_inc_d;
   logic              rw_q;
   logic              sda_oe_q, busy_q, wr_strobe_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic [7:0]        regs_q [DEPTH];
   logic              i2c_we_s;

   // Two-flop synchronizers, idle-high so reset never looks like a bus condition
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
      end else begin
         scl_s1_q <= scl_i;
         scl_s2_q <= scl_s1_q;
         sda_s1_q <= sda_i;
         sda_s2_q <= sda_s1_q;
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [2:0] scl_hist_q, sda_hist_q;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   // Last three synchronized samples of each line for the majority vote
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_hist_q <= 3'b111;
         sda_hist_q <= 3'b111;
      end else begin
         scl_hist_q <= {scl_hist_q[1:0], scl_s2_q};
         sda_hist_q <= {sda_hist_q[1:0], sda_s2_q};
      end
   end

   assign scl_f_s = maj3(scl_hist_q);
   assign sda_f_s = maj3(sda_hist_q);
`else
   assign scl_f_s = scl_s2_q;
   assign sda_f_s = sda_s2_q;
`endif

   // Delay stage for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_prev_q <= scl_f_s;
         sda_prev_q <= sda_f_s;
      end
   end

   assign scl_rise_s = scl_f_s & ~scl_prev_q;
   assign scl_fall_s = ~scl_f_s & scl_prev_q;
   assign start_s    = scl_f_s & scl_prev_q & sda_prev_q & ~sda_f_s;
   assign stop_s     = scl_f_s & scl_prev_q & ~sda_prev_q & sda_f_s;

   assign byte_d    = {shreg_q[6:0], sda_f_s};
   assign ptr_inc_d = ptr_q + ADDR_W'(1);
   assign i2c_we_s  = (state_q == ST_WRDATA) && scl_rise_s && !start_s && !stop_s &&
                      (bitcnt_q == 4'd7);

   // Protocol FSM; bitcnt_q == 8 marks the ACK slot of the current byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         bitcnt_q    <= 4'd0;
         shreg_q     <= 8'd0;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'd0;
      end else begin
         wr_strobe_q <= 1'b0;
         if (stop_s) begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            bitcnt_q <= 4'd0;
         end else if (start_s) begin
            state_q  <= ST_ADDR;
            sda_oe_q <= 1'b0;
            bitcnt_q <= 4'd0;
         end else if (scl_rise_s) begin
            case (state_q)
               ST_ADDR: begin
                  shreg_q  <= byte_d;
                  bitcnt_q <= bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd7) begin
                     if (byte_d[7:1] == SLAVE_ADDR) begin
                        state_q <= ST_ADDR_ACK;
                        busy_q  <= 1'b1;
                        rw_q    <= byte_d[0];
                     end else begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        bitcnt_q <= 4'd0;
                     end
                  end
               end
               ST_ADDR_ACK: bitcnt_q <= 4'd0;
               ST_MEMADDR: begin
                  if (bitcnt_q == 4'd8) begin
                     state_q  <= ST_WRDATA;
                     bitcnt_q <= 4'd0;
                  end else begin
                     shreg_q  <= byte_d;
                     bitcnt_q <= bitcnt_q + 4'd1;
                     if (bitcnt_q == 4'd7) begin
                        ptr_q <= byte_d[ADDR_W-1:0];
                     end
                  end
               end
               ST_WRDATA: begin
                  if (bitcnt_q == 4'd8) begin
                     bitcnt_q <= 4'd0;
                  end else begin
                     shreg_q  <= byte_d;
                     bitcnt_q <= bitcnt_q + 4'd1;
                     if (bitcnt_q == 4'd7) begin
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= ptr_q;
                        wr_data_q   <= byte_d;
                        ptr_q       <= ptr_inc_d;
                     end
                  end
               end
               ST_RDDATA: begin
                  if (bitcnt_q == 4'd8) begin
                     bitcnt_q <= 4'd0;
                     if (!sda_f_s) begin
                        shreg_q <= regs_q[ptr_q];
                        ptr_q   <= ptr_inc_d;
                     end else begin
                        state_q <= ST_RD_NACK;
                     end
                  end else begin
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end
               end
               default: ;
            endcase
         end else if (scl_fall_s) begin
            case (state_q)
               ST_ADDR_ACK: begin
                  if (bitcnt_q == 4'd8) begin
                     sda_oe_q <= 1'b1;
                  end else if (rw_q) begin
                     state_q  <= ST_RDDATA;
                     shreg_q  <= regs_q[ptr_q];
                     sda_oe_q <= ~regs_q[ptr_q][7];
                     ptr_q    <= ptr_inc_d;
                  end else begin
                     state_q  <= ST_MEMADDR;
                     sda_oe_q <= 1'b0;
                  end
               end
               ST_MEMADDR, ST_WRDATA: sda_oe_q <= (bitcnt_q == 4'd8);
               ST_RDDATA: begin
                  if (bitcnt_q == 4'd8) begin
                     sda_oe_q <= 1'b0;
                  end else begin
                     sda_oe_q <= ~shreg_q[3'd7 - bitcnt_q[2:0]];
                  end
               end
               ST_RD_NACK: begin
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
                  sda_oe_q <= 1'b0;
               end
               default: sda_oe_q <= 1'b0;
            endcase
         end
      end
   end

   // Register file; a bus write beats a same-index host write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i2c_we_s && (ptr_q == ADDR_W'(i))) begin
               regs_q[i] <= byte_d;
            end else if (host_we && (host_addr == ADDR_W'(i))) begin
               regs_q[i] <= host_wdata;
            end
         end
      end
   end

   assign host_rdata = regs_q[host_addr];
   assign sda_oe     = sda_oe_q;
   assign busy       = busy_q;
   assign wr_strobe  = wr_strobe_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
I2C slave responder with a small byte register file, answering the same transaction the existing Wishbone-side I2C master sequence issues.
- Write sequence: START, {addr,W}, mem addr, data..., STOP.
- Read sequence: START, {addr,W}, mem addr, Sr, {addr,R}, data, NACK, STOP.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain.
- Used as the bus-end model and peripheral for the master controller.

Parameters:
SLAVE_ADDR, 7'b0010_000, 7-bit device address matched on the bus.
DEPTH, 8, number of byte registers (power of 2).
ADDR_W, 3, log2(DEPTH); register pointer width.

Ports:
clk  in  1  system clock; SCL frequency at least 8x below clk.
rst  in  1  asynchronous, active-low reset.
scl_i  in  1  raw SCL pad input.
sda_i  in  1  raw SDA pad input.
sda_oe  out  1  1 = pull SDA low; 0 = release.
busy  out  1  high from address match until STOP, mismatch or NACK-return to idle.
host_we  in  1  local register write strobe.
host_addr  in  ADDR_W  local register index (write and read).
host_wdata  in  8  local write data.
host_rdata  out  8  combinational regs[host_addr].
wr_strobe  out  1  1-cycle pulse per byte written over I2C.
wr_addr  out  ADDR_W  index of the byte just written.
wr_data  out  8  value of the byte just written.

Behaviour:
- Reset (rst=0, async):
  - sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0.
  - All regs=0, ptr=0, state=IDLE.
  - Synchronizers preset to 1.
- Input conditioning:
  - 2-flop synchronizers on scl/sda, plus one delay stage for edge detection.
  - scl_rise/scl_fall/sda edges are 1-cycle pulses on synchronized signals.
- Bus conditions:
  - START/Sr = sda fall while scl=1.
  - STOP = sda rise while scl=1.
  - Both are detected in any state and take priority over bit processing.
- Bit timing:
  - Received bit sampled on scl_rise.
  - sda_oe changes only in the cycle after scl_fall.
  - Bits are MSB first; a bit counter of 0..8 counts the 9th bit as ACK.
- States:
  - IDLE: sda_oe=0. START -> ADDR.
  - ADDR: shift 8 bits, then check {addr,rw}.
    - addr==SLAVE_ADDR: -> ADDR_ACK and busy=1.
    - Otherwise: -> IDLE without driving (NACK).
  - ADDR_ACK: sda_oe=1 from the scl_fall after bit 8 to the scl_fall after bit 9.
    - rw=0 -> MEMADDR.
    - rw=1 -> load shreg=regs[ptr], ptr=ptr+1, -> RDDATA.
  - MEMADDR: shift 8 bits, ptr = byte[ADDR_W-1:0] (upper bits ignored). ACK -> WRDATA.
  - WRDATA: shift 8 bits, then ACK.
    - On the 8th scl_rise: regs[ptr]=byte, wr_strobe pulse (wr_addr=ptr, wr_data=byte), ptr=ptr+1.
    - Loops for multi-byte writes.
  - RDDATA: sda_oe = ~shreg[7-bitcnt] for bits 0..7, then release for the master ACK.
    - Master ACK (sda=0 on 9th rise): reload shreg=regs[ptr], ptr++, stay in RDDATA.
    - Master NACK: -> IDLE; busy=0 after the following scl_fall.
- Pointer: ptr increments modulo DEPTH (DEPTH-1 -> 0).
- Sr in any state: release sda_oe next cycle, -> ADDR. ptr is retained; this is the write-addr-then-read case.
- STOP in any state: sda_oe=0, busy=0, -> IDLE. A partial byte is discarded with no reg write and no strobe.
- Collision: I2C write and host_we to the same index in the same cycle -> the I2C write wins. Different indices -> both complete.
- A reset mid-transfer releases SDA immediately (async).

Optional Feature:
Macro I2C_GLITCH_FILTER_EN.
- Defined:
  - A 3-sample majority filter on each synchronized line, using the last 3 clk samples.
  - Suppresses 1-cycle spikes.
  - Adds 2 cycles of detection latency to all edges/conditions.
- Undefined: no filter; edges are detected directly from the 2-flop synchronizer output.

Test Plan:
- Reset: rst=0 mid-byte with sda_oe=1 -> sda_oe=0 within the same cycle; after release, busy=0 and host_rdata=0x00 for all indices.
- Single write: START, 0x20, 0x06, 0xA5, STOP -> three ACKs, one wr_strobe with wr_addr=6, wr_data=0xA5; host_rdata@6=0xA5.
- Random read: host preload regs[6]=0x3C; START 0x20, 0x06, Sr, 0x21 -> slave drives 0x3C MSB first; master NACK, STOP -> sda_oe=0, busy=0.
- Burst/wrap write: START 0x20, 0x07, then 0x11, 0x22 -> regs[7]=0x11, regs[0]=0x22, with two wr_strobe pulses.
- Address mismatch: START 0x40 (7'h20, W) -> no ACK (sda_oe stays 0), busy=0; following bytes are ignored until the next START.
- Abort: STOP after 4 data bits of a WRDATA byte -> no wr_strobe, reg unchanged, state IDLE. With I2C_GLITCH_FILTER_EN, a 1-cycle SDA low pulse while SCL high produces no false START.
